// File: rtl/pow2_div_pkg.sv
// Shared types and constants for the serial signed divide-by-2^S unit.
package pow2_div_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Rounding-mode encodings for the in_trunc input
  localparam logic RND_FLOOR = 1'b0;
  localparam logic RND_TRUNC = 1'b1;

endpackage

// File: rtl/signed_pow2_round_fix.sv
// Converts a floor-rounded quotient/remainder pair into round-toward-zero form.
// Ports:
//   q_floor  - quotient after S arithmetic right shifts (rounded toward -inf)
//   rem_raw  - low S bits shifted out of the dividend (0..2^S-1)
//   shift    - S
//   mode     - RND_TRUNC or RND_FLOOR
//   sign     - dividend sign bit
//   q_c      - corrected quotient
//   rem_c    - corrected signed remainder
module signed_pow2_round_fix
  import pow2_div_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic [N-1:0]  q_floor,
  input  logic [N-1:0]  rem_raw,
  input  logic [SW-1:0] shift,
  input  logic          mode,
  input  logic          sign,
  output logic [N-1:0]  q_c,
  output logic [N-1:0]  rem_c
);

  logic         fix_c;
  logic [N-1:0] step_c;

  // A negative dividend with a nonzero remainder was rounded down; nudge it up by one.
  always_comb begin
    fix_c  = (mode == RND_TRUNC) && sign && (rem_raw != '0);
    step_c = N'(1) << shift;
    q_c    = q_floor;
    rem_c  = rem_raw;
    if (fix_c) begin
      q_c   = q_floor + N'(1);
      rem_c = rem_raw - step_c;
    end
  end

endmodule

// File: rtl/signed_divide_by_power_of_2_serial.sv
// Serial signed divide by 2^S: one arithmetic shift per cycle, then a single
// rounding correction. Valid/ready handshake on input and output.
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   in_valid/in_ready    - request handshake
//   in_data              - dividend (two's complement)
//   in_shift             - S, clamped to N-1
//   in_trunc             - 1: round toward zero, 0: floor
//   out_valid/out_ready  - result handshake
//   out_quot, out_rem    - quotient and remainder, in_data == quot*2^S + rem
module signed_divide_by_power_of_2_serial
  import pow2_div_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic [SW-1:0] in_shift,
  input  logic          in_trunc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_quot,
  output logic [N-1:0]  out_rem
);

  localparam int unsigned SWX = SW + 1;

  state_t        state, state_d;
  logic [N-1:0]  q, q_d;
  logic [N-1:0]  rem, rem_d;
  logic [SW-1:0] cnt, cnt_d;
  logic [SW-1:0] k, k_d;
  logic [SW-1:0] shift_r, shift_d;
  logic          mode, mode_d;
  logic          in_ready_d, out_valid_d;
  logic [N-1:0]  out_quot_d, out_rem_d;

  logic [SWX-1:0] shift_wide_c;
  logic [SW-1:0]  shift_clamp_c;
  logic [N-1:0]   q_fix_c, rem_fix_c;

  // Clamp the requested shift to N-1 (compare one bit wider so the test is never constant)
  always_comb begin
    shift_wide_c  = {1'b0, in_shift};
    shift_clamp_c = in_shift;
    if (shift_wide_c > SWX'(N - 1)) begin
      shift_clamp_c = SW'(N - 1);
    end
  end

  signed_pow2_round_fix #(
    .N  (N),
    .SW (SW)
  ) u_round_fix (
    .q_floor (q),
    .rem_raw (rem),
    .shift   (shift_r),
    .mode    (mode),
    .sign    (q[N-1]),
    .q_c     (q_fix_c),
    .rem_c   (rem_fix_c)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q         <= '0;
      rem       <= '0;
      cnt       <= '0;
      k         <= '0;
      shift_r   <= '0;
      mode      <= RND_FLOOR;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_quot  <= '0;
      out_rem   <= '0;
    end else begin
      state     <= state_d;
      q         <= q_d;
      rem       <= rem_d;
      cnt       <= cnt_d;
      k         <= k_d;
      shift_r   <= shift_d;
      mode      <= mode_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_quot  <= out_quot_d;
      out_rem   <= out_rem_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    q_d        = q;
    rem_d      = rem;
    cnt_d      = cnt;
    k_d        = k;
    shift_d    = shift_r;
    mode_d     = mode;
    out_quot_d = out_quot;
    out_rem_d  = out_rem;

    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          q_d     = in_data;
          rem_d   = '0;
          cnt_d   = shift_clamp_c;
          shift_d = shift_clamp_c;
          k_d     = '0;
          mode_d  = in_trunc;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt != '0) begin
          // Shifted-out LSB lands at bit k of the remainder
          rem_d[k] = q[0];
          q_d      = {q[N-1], q[N-1:1]};
          k_d      = k + SW'(1);
          cnt_d    = cnt - SW'(1);
        end else begin
          out_quot_d = q_fix_c;
          out_rem_d  = rem_fix_c;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

endmodule
